vga_bounce_overlay: RTL and testbench



---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_timing_gen.sv | 66 ++++++
 rtl/vga_bounce_overlay.sv | 199 +++++++++++++++++++
 tb/tb_vga_bounce_overlay.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-window VGA controller: run modes,
// background band palette (3-3-2) and the timing-total helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_FREEZE = 2'd1,
        MODE_CENTRE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    // red, green, blue, yellow, cyan, magenta, white, grey
    localparam logic [7:0] BAND_COLOR [8] = '{
        8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'hFF, 8'h92
    };

    function automatic int timing_total(input int sync_w, input int back_w,
                                        input int active_w, input int front_w);
        return sync_w + back_w + active_w + front_w;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for one VGA mode: raw sync pulses, active flag, active-area
// offsets and the last-clock-of-frame strobe, all un-registered.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    localparam int H_TOT   = timing_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT),
    localparam int V_TOT   = timing_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT),
    localparam int HW      = $clog2(H_TOT),
    localparam int VW      = $clog2(V_TOT),
    localparam int AHW     = $clog2(H_ACTIVE),
    localparam int AVW     = $clog2(V_ACTIVE)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           o_hsync_raw,
    output logic           o_vsync_raw,
    output logic           o_de_raw,
    output logic [AHW-1:0] o_ah,
    output logic [AVW-1:0] o_av,
    output logic           o_frame_end
);

    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    logic [HW-1:0] r_cnt_h;
    logic [VW-1:0] r_cnt_v;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_h_act;
    logic          w_v_act;

    assign w_h_last = (r_cnt_h == HW'(H_TOT - 1));
    assign w_v_last = (r_cnt_v == VW'(V_TOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (w_h_last) begin
            r_cnt_h <= '0;
            r_cnt_v <= w_v_last ? '0 : r_cnt_v + VW'(1);
        end else begin
            r_cnt_h <= r_cnt_h + HW'(1);
        end
    end

    assign w_h_act = (r_cnt_h >= HW'(H_START)) && (r_cnt_h < HW'(H_START + H_ACTIVE));
    assign w_v_act = (r_cnt_v >= VW'(V_START)) && (r_cnt_v < VW'(V_START + V_ACTIVE));

    assign o_hsync_raw = (r_cnt_h < HW'(H_SYNC));
    assign o_vsync_raw = (r_cnt_v < VW'(V_SYNC));
    assign o_de_raw    = w_h_act && w_v_act;
    assign o_ah        = w_h_act ? AHW'(r_cnt_h - HW'(H_START)) : '0;
    assign o_av        = w_v_act ? AVW'(r_cnt_v - VW'(V_START)) : '0;
    assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/vga_bounce_overlay.sv
// VGA controller: colour-band background with an image window that bounces,
// freezes or centres once per frame; image pixels come from a fixed-latency port.
module vga_bounce_overlay
    import vga_pkg::*;
#(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int IMG_W    = 198,
    parameter int IMG_H    = 198,
    parameter int RGB_W    = 8,
    parameter int STEP     = 1,
    parameter int NUM_BARS = 3,
    parameter int RD_LAT   = 1,
    localparam int IMG_N   = IMG_W * IMG_H,
    localparam int AW      = $clog2(IMG_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    output logic             img_rd,
    output logic [AW-1:0]    img_addr,
    input  logic [RGB_W-1:0] img_data,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_end
);

    localparam int XMAX   = H_ACTIVE - IMG_W;
    localparam int YMAX   = V_ACTIVE - IMG_H;
    localparam int XW     = $clog2(H_ACTIVE + 1);
    localparam int YW     = $clog2(V_ACTIVE + 1);
    localparam int AHW    = $clog2(H_ACTIVE);
    localparam int AVW    = $clog2(V_ACTIVE);
    localparam int BAND_H = V_ACTIVE / NUM_BARS;
    localparam int LAST   = RD_LAT - 1;

    logic           w_hs_raw, w_vs_raw, w_de_raw, w_frame_end;
    logic [AHW-1:0] w_ah;
    logic [AVW-1:0] w_av;

    vga_timing_gen #(
        .H_SYNC  (H_SYNC),  .H_BACK (H_BACK),  .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC  (V_SYNC),  .V_BACK (V_BACK),  .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_hsync_raw(w_hs_raw),
        .o_vsync_raw(w_vs_raw),
        .o_de_raw   (w_de_raw),
        .o_ah       (w_ah),
        .o_av       (w_av),
        .o_frame_end(w_frame_end)
    );

    mode_e         r_mode;
    logic [XW-1:0] r_x, w_x_nxt;
    logic [YW-1:0] r_y, w_y_nxt;
    logic          r_neg_x, r_neg_y, w_neg_x_nxt, w_neg_y_nxt;

    // Position for the next frame, decided by the mode that governed this one
    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_neg_x_nxt = r_neg_x;
        w_neg_y_nxt = r_neg_y;
        case (r_mode)
            MODE_BOUNCE: begin
                if (!r_neg_x) begin
                    if (32'(r_x) + STEP > XMAX) begin
                        w_x_nxt     = XW'(XMAX);
                        w_neg_x_nxt = 1'b1;
                    end else begin
                        w_x_nxt = r_x + XW'(STEP);
                    end
                end else if (32'(r_x) < STEP) begin
                    w_x_nxt     = '0;
                    w_neg_x_nxt = 1'b0;
                end else begin
                    w_x_nxt = r_x - XW'(STEP);
                end
                if (!r_neg_y) begin
                    if (32'(r_y) + STEP > YMAX) begin
                        w_y_nxt     = YW'(YMAX);
                        w_neg_y_nxt = 1'b1;
                    end else begin
                        w_y_nxt = r_y + YW'(STEP);
                    end
                end else if (32'(r_y) < STEP) begin
                    w_y_nxt     = '0;
                    w_neg_y_nxt = 1'b0;
                end else begin
                    w_y_nxt = r_y - YW'(STEP);
                end
            end
            MODE_CENTRE: begin
                w_x_nxt     = XW'(XMAX / 2);
                w_y_nxt     = YW'(YMAX / 2);
                w_neg_x_nxt = 1'b0;
                w_neg_y_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_BOUNCE;
            r_x     <= '0;
            r_y     <= '0;
            r_neg_x <= 1'b0;
            r_neg_y <= 1'b0;
        end else if (w_frame_end) begin
            r_mode  <= mode_e'(mode_i);
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_neg_x <= w_neg_x_nxt;
            r_neg_y <= w_neg_y_nxt;
        end
    end

    logic             w_hit;
    logic [RGB_W-1:0] w_band;
    logic [AW-1:0]    r_addr;

    assign w_hit = w_de_raw && (r_mode != MODE_OFF)
                && (32'(w_ah) >= 32'(r_x)) && (32'(w_ah) < 32'(r_x) + IMG_W)
                && (32'(w_av) >= 32'(r_y)) && (32'(w_av) < 32'(r_y) + IMG_H);

    // Lines below the last whole band stay black
    always_comb begin
        w_band = '0;
        if (32'(w_av) < NUM_BARS * BAND_H)
            w_band = RGB_W'(BAND_COLOR[3'(32'(w_av) / BAND_H)]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_addr <= '0;
        else if (w_frame_end)
            r_addr <= '0;
        else if (w_hit)
            r_addr <= (r_addr == AW'(IMG_N - 1)) ? '0 : r_addr + AW'(1);
    end

    assign img_rd    = w_hit;
    assign img_addr  = r_addr;
    assign frame_end = w_frame_end;

    logic [RD_LAT-1:0] r_hs_d, r_vs_d, r_de_d, r_hit_d;
    logic [RGB_W-1:0]  r_band_d [RD_LAT];

    // Delay line matching the image read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d   <= '0;
            r_vs_d   <= '0;
            r_de_d   <= '0;
            r_hit_d  <= '0;
            r_band_d <= '{default: '0};
        end else begin
            r_hs_d[0]   <= w_hs_raw;
            r_vs_d[0]   <= w_vs_raw;
            r_de_d[0]   <= w_de_raw;
            r_hit_d[0]  <= w_hit;
            r_band_d[0] <= w_band;
            for (int i = 1; i < RD_LAT; i++) begin
                r_hs_d[i]   <= r_hs_d[i-1];
                r_vs_d[i]   <= r_vs_d[i-1];
                r_de_d[i]   <= r_de_d[i-1];
                r_hit_d[i]  <= r_hit_d[i-1];
                r_band_d[i] <= r_band_d[i-1];
            end
        end
    end

    // Output stage: image pixel arrives in step with the delayed hit flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            de    <= 1'b0;
            rgb   <= '0;
        end else begin
            hsync <= r_hs_d[LAST];
            vsync <= r_vs_d[LAST];
            de    <= r_de_d[LAST];
            rgb   <= r_hit_d[LAST] ? img_data : (r_de_d[LAST] ? r_band_d[LAST] : '0);
        end
    end

endmodule

// File: tb/tb_vga_bounce_overlay.sv
// Directed bench for vga_bounce_overlay on a reduced 22x16 raster with a 6x4 window.
module tb_vga_bounce_overlay;

    localparam int HT  = 22;
    localparam int VT  = 16;
    localparam int FT  = HT * VT;
    localparam int LAT = 3;
    localparam int H0  = 4;
    localparam int V0  = 2;
    localparam int NF  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_i;
    logic       img_rd;
    logic [4:0] img_addr;
    logic [7:0] img_data;
    logic       hsync, vsync, de, frame_end;
    logic [7:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    vga_bounce_overlay #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(16), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(13), .V_FRONT(1),
        .IMG_W(6), .IMG_H(4), .RGB_W(8), .STEP(3), .NUM_BARS(3), .RD_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    // Image memory with two clocks of read latency
    logic [4:0] m_q0, m_q1;
    always @(posedge clk) begin
        m_q0 <= img_addr;
        m_q1 <= m_q0;
    end
    assign img_data = 8'(int'(m_q1) * 7 + 1);

    function automatic int dat(input int a);
        return (a * 7 + 1) % 256;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int x_tab    [NF] = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3, 6, 6, 5, 5, 8, 10};
    int y_tab    [NF] = '{0, 3, 6, 9, 9, 6, 3, 0, 0, 3, 6, 6, 4, 4, 7, 9};
    int mode_tab [NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
    int band_tab [3]  = '{8'hE0, 8'h1C, 8'h03};

    int k, len, p, h, v, ah, av, md, e_rgb, rd_cnt, rd_exp;
    int x_obs, y_obs, addr_err, sync_err, rgb_err, n;
    logic act, done;

    initial begin
        rst_n  = 1'b0;
        mode_i = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_img_rd", int'(img_rd), 0);
        chk("rst_img_addr", int'(img_addr), 0);
        chk("rst_frame_end", int'(frame_end), 0);
        rst_n = 1'b1;
        k = 1;

        for (int f = 0; f < NF; f++) begin
            len      = (f == 0) ? 1 : 0;
            rd_cnt   = 0;
            x_obs    = -1;
            y_obs    = -1;
            addr_err = 0;
            sync_err = 0;
            rgb_err  = 0;
            done     = 1'b0;
            md       = (f == 0) ? 0 : mode_tab[f-1];
            rd_exp   = (md == 3) ? 0 : 24;
            while (!done) begin
                @(negedge clk);
                if (k == 100) mode_i = 2'(mode_tab[f]);
                if (img_rd) begin
                    if (rd_cnt == 0) begin
                        x_obs = k % HT - H0;
                        y_obs = k / HT - V0;
                    end
                    if (int'(img_addr) != rd_cnt) addr_err++;
                    rd_cnt++;
                end
                p = k - LAT;
                if (p < 0) p += FT;
                h     = p % HT;
                v     = p / HT;
                act   = (h >= H0) && (h < H0 + 16) && (v >= V0) && (v < V0 + 13);
                e_rgb = 0;
                if (act) begin
                    ah = h - H0;
                    av = v - V0;
                    if (md != 3 && ah >= x_tab[f] && ah < x_tab[f] + 6 &&
                        av >= y_tab[f] && av < y_tab[f] + 4)
                        e_rgb = dat((av - y_tab[f]) * 6 + ah - x_tab[f]);
                    else if (av < 12)
                        e_rgb = band_tab[av / 4];
                end
                if (hsync !== (h < 2) || vsync !== (v < 1) || de !== act) sync_err++;
                if (rgb !== 8'(e_rgb)) rgb_err++;
                len++;
                if (frame_end === 1'b1) begin
                    done = 1'b1;
                    k    = 0;
                end else begin
                    k++;
                end
                if (len > FT + 10) done = 1'b1;
            end
            chk($sformatf("f%0d_frame_len", f), len, FT);
            chk($sformatf("f%0d_rd_count", f), rd_cnt, rd_exp);
            chk($sformatf("f%0d_addr_err", f), addr_err, 0);
            chk($sformatf("f%0d_sync_err", f), sync_err, 0);
            chk($sformatf("f%0d_rgb_err", f), rgb_err, 0);
            if (rd_exp > 0) begin
                chk($sformatf("f%0d_x", f), x_obs, x_tab[f]);
                chk($sformatf("f%0d_y", f), y_obs, y_tab[f]);
            end
        end

        // Asynchronous reset in the middle of an active line
        n = 0;
        while (!(de === 1'b1 && rgb !== 8'h00) && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wait_active", int'(n < 2 * FT), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync", int'(hsync), 0);
        chk("mid_rst_vsync", int'(vsync), 0);
        chk("mid_rst_de", int'(de), 0);
        chk("mid_rst_rgb", int'(rgb), 0);
        chk("mid_rst_img_rd", int'(img_rd), 0);
        chk("mid_rst_img_addr", int'(img_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hsync !== 1'b1 && n < 10);
        chk("rel_hsync_latency", n, LAT);
        chk("rel_img_addr", int'(img_addr), 0);
        chk("rel_img_rd", int'(img_rd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
